// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between write-back (priority) and debug writes.
// A debug request that cannot find a free slot in time forces a one-cycle pipeline stall.
module regfile_wr_arbiter #(
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inWB_wr,
   input  logic [4:0]  inWB_wa,
   input  logic [31:0] inWB_wd,
   input  logic        inDbg_req,
   input  logic [4:0]  inDbg_wa,
   input  logic [31:0] inDbg_wd,
   output logic        outDbg_ack,
   output logic        outStall,
   output logic        outRegF_wr,
   output logic [4:0]  outRegF_wa,
   output logic [31:0] outRegF_wd
);

   localparam int CW = $clog2(STARVE_MAX) + 1;
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_STALL = CW'(STARVE_MAX - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;

   logic          w_free;
   logic          w_grant;
   logic          w_stall;
   logic          w_wr;
   logic [4:0]    w_wa;
   logic [31:0]   w_wd;
   logic [CW-1:0] w_cnt_inc;

   // A write-back write to r0 is discarded anyway, so that slot is usable by debug.
   assign w_free    = ~inWB_wr | (inWB_wa == 5'd0);
   assign w_cnt_inc = r_cnt + CNT_ONE;

   // Grant decision and write-port mux.
   always_comb begin
      w_grant = 1'b0;
      w_stall = 1'b0;
      case (r_state)
         IDLE:    w_grant = inDbg_req & w_free;
         WAIT:    w_grant = inDbg_req & w_free;
         STALL: begin
            w_grant = inDbg_req;
            w_stall = 1'b1;
         end
         default: w_grant = 1'b0;
      endcase

      if (w_grant) begin
         w_wr = (inDbg_wa != 5'd0);
         w_wa = inDbg_wa;
         w_wd = inDbg_wd;
      end else begin
         // During the stall the write-back contents are re-presented next cycle.
         w_wr = inWB_wr & (inWB_wa != 5'd0) & ~w_stall;
         w_wa = inWB_wa;
         w_wd = inWB_wd;
      end
   end

   // Outputs are held quiet while reset is asserted.
   assign outDbg_ack = rst & w_grant;
   assign outStall   = rst & w_stall;
   assign outRegF_wr = rst & w_wr;
   assign outRegF_wa = rst ? w_wa : 5'd0;
   assign outRegF_wd = rst ? w_wd : 32'd0;

   // State and wait counter; r_cnt holds the number of cycles the request has already waited,
   // so the stall lands in the STARVE_MAX-th cycle after the request first appears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= CNT_ZERO;
      end else begin
         case (r_state)
            IDLE: begin
               if (inDbg_req && !w_free) begin
                  r_state <= (CNT_ONE == CNT_STALL) ? STALL : WAIT;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_state <= IDLE;
                  r_cnt   <= CNT_ZERO;
               end
            end
            WAIT: begin
               if (!inDbg_req || w_free) begin
                  r_state <= IDLE;
                  r_cnt   <= CNT_ZERO;
               end else if (w_cnt_inc == CNT_STALL) begin
                  r_state <= STALL;
                  r_cnt   <= w_cnt_inc;
               end else begin
                  r_state <= WAIT;
                  r_cnt   <= w_cnt_inc;
               end
            end
            STALL: begin
               r_state <= IDLE;
               r_cnt   <= CNT_ZERO;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: a vector table on the STARVE_MAX=8 instance plus hand sequences for
// starvation, stall with dropped request, and asynchronous reset.
module tb_regfile_wr_arbiter;

   typedef struct {
      logic        wb_wr;
      logic [4:0]  wb_wa;
      logic [31:0] wb_wd;
      logic        req;
      logic [4:0]  dbg_wa;
      logic [31:0] dbg_wd;
      logic        ack;
      logic        stall;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        wb_wr;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        req;
   logic [4:0]  dbg_wa;
   logic [31:0] dbg_wd;

   logic        o8_ack, o8_stall, o8_wr;
   logic [4:0]  o8_wa;
   logic [31:0] o8_wd;
   logic        o4_ack, o4_stall, o4_wr;
   logic [4:0]  o4_wa;
   logic [31:0] o4_wd;

   int n_err = 0;
   int n_chk = 0;
   vec_t vecs[$];

   regfile_wr_arbiter u_dut8 (
      .clk(clk), .rst(rst),
      .inWB_wr(wb_wr), .inWB_wa(wb_wa), .inWB_wd(wb_wd),
      .inDbg_req(req), .inDbg_wa(dbg_wa), .inDbg_wd(dbg_wd),
      .outDbg_ack(o8_ack), .outStall(o8_stall),
      .outRegF_wr(o8_wr), .outRegF_wa(o8_wa), .outRegF_wd(o8_wd)
   );

   regfile_wr_arbiter #(.STARVE_MAX(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .inWB_wr(wb_wr), .inWB_wa(wb_wa), .inWB_wd(wb_wd),
      .inDbg_req(req), .inDbg_wa(dbg_wa), .inDbg_wd(dbg_wd),
      .outDbg_ack(o4_ack), .outStall(o4_stall),
      .outRegF_wr(o4_wr), .outRegF_wa(o4_wa), .outRegF_wd(o4_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk8(input string nm, input int idx, input logic e_ack, input logic e_stall,
                       input logic e_wr, input logic [4:0] e_wa, input logic [31:0] e_wd);
      chk({nm, ".ack"},   idx, 32'(o8_ack),   32'(e_ack));
      chk({nm, ".stall"}, idx, 32'(o8_stall), 32'(e_stall));
      chk({nm, ".wr"},    idx, 32'(o8_wr),    32'(e_wr));
      chk({nm, ".wa"},    idx, 32'(o8_wa),    32'(e_wa));
      chk({nm, ".wd"},    idx, o8_wd,         e_wd);
   endtask

   task automatic chk4(input string nm, input int idx, input logic e_ack, input logic e_stall,
                       input logic e_wr, input logic [4:0] e_wa, input logic [31:0] e_wd);
      chk({nm, ".ack"},   idx, 32'(o4_ack),   32'(e_ack));
      chk({nm, ".stall"}, idx, 32'(o4_stall), 32'(e_stall));
      chk({nm, ".wr"},    idx, 32'(o4_wr),    32'(e_wr));
      chk({nm, ".wa"},    idx, 32'(o4_wa),    32'(e_wa));
      chk({nm, ".wd"},    idx, o4_wd,         e_wd);
   endtask

   task automatic add(input logic v_wr, input logic [4:0] v_wa, input logic [31:0] v_wd,
                      input logic v_req, input logic [4:0] v_dwa, input logic [31:0] v_dwd,
                      input logic e_ack, input logic e_stall, input logic e_wr,
                      input logic [4:0] e_wa, input logic [31:0] e_wd);
      vecs.push_back('{v_wr, v_wa, v_wd, v_req, v_dwa, v_dwd, e_ack, e_stall, e_wr, e_wa, e_wd});
   endtask

   task automatic drive(input logic v_wr, input logic [4:0] v_wa, input logic [31:0] v_wd,
                        input logic v_req, input logic [4:0] v_dwa, input logic [31:0] v_dwd);
      wb_wr = v_wr; wb_wa = v_wa; wb_wd = v_wd;
      req = v_req; dbg_wa = v_dwa; dbg_wd = v_dwd;
   endtask

   // Called just after a rising edge; returns just after the next rising edge in IDLE.
   task automatic do_reset();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst = 1'b0;
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // free-slot grant, busy write, r0 handling
      add(1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF);
      add(1'b1, 5'd3, 32'h11, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd3,  32'h11);
      add(1'b1, 5'd0, 32'h22, 1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 1'b1, 5'd9,  32'h99);
      add(1'b0, 5'd0, 32'h0,  1'b1, 5'd0,  32'h55,       1'b1, 1'b0, 1'b0, 5'd0,  32'h55);
      add(1'b1, 5'd0, 32'h77, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h77);
      // pipeline priority for three cycles, then the freed slot goes to debug
      for (int i = 0; i < 3; i++)
         add(1'b1, 5'd3, 32'h11, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11);
      add(1'b0, 5'd3, 32'h11, 1'b1, 5'd12, 32'hC0FFEE,  1'b1, 1'b0, 1'b1, 5'd12, 32'hC0FFEE);
      add(1'b1, 5'd3, 32'h11, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5'd3,  32'h11);
      // withdraw after two waiting cycles
      for (int i = 0; i < 2; i++)
         add(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44);
      add(1'b1, 5'd4, 32'h44, 1'b0, 5'd6,  32'h66,       1'b0, 1'b0, 1'b1, 5'd4,  32'h44);
      // fresh request after withdraw waits the full 7 cycles, stall lands on the 8th
      for (int i = 0; i < 7; i++)
         add(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44);
      add(1'b1, 5'd4, 32'h44, 1'b1, 5'd6,  32'h66,       1'b1, 1'b1, 1'b1, 5'd6,  32'h66);
      add(1'b1, 5'd4, 32'h44, 1'b0, 5'd6,  32'h66,       1'b0, 1'b0, 1'b1, 5'd4,  32'h44);

      // reset state: outputs forced low even with a grantable request present
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
      #2;
      chk8("reset8", 0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk4("reset4", 0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].wb_wr, vecs[i].wb_wa, vecs[i].wb_wd, vecs[i].req, vecs[i].dbg_wa, vecs[i].dbg_wd);
         @(negedge clk);
         chk8("vec", i, vecs[i].ack, vecs[i].stall, vecs[i].wr, vecs[i].wa, vecs[i].wd);
         @(posedge clk);
         #1;
      end

      // starvation with STARVE_MAX=4
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 5'd7, 32'h77777777, (c < 4) ? 1'b1 : 1'b0, 5'd10, 32'hABCD);
         @(negedge clk);
         if (c == 3) chk4("starve", c, 1'b1, 1'b1, 1'b1, 5'd10, 32'hABCD);
         else        chk4("starve", c, 1'b0, 1'b0, 1'b1, 5'd7,  32'h77777777);
         @(posedge clk);
         #1;
      end

      // request dropped in the stall cycle: stall still lasts one cycle, nothing written
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 5'd7, 32'h77777777, (c < 3) ? 1'b1 : 1'b0, 5'd10, 32'hABCD);
         @(negedge clk);
         if (c == 3) chk4("dropst", c, 1'b0, 1'b1, 1'b0, 5'd7, 32'h77777777);
         else        chk4("dropst", c, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77777777);
         @(posedge clk);
         #1;
      end

      // asynchronous reset while waiting with cnt=3
      do_reset();
      drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd8, 32'h8888);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b0;
      #1;
      chk8("areset", 0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      req = 1'b0;
      #3;
      rst = 1'b1;
      @(negedge clk);
      chk8("postrst", 0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h2222);
      @(posedge clk);
      #1;
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd8, 32'h8888);
         @(negedge clk);
         if (c == 7) chk8("restarve", c, 1'b1, 1'b1, 1'b1, 5'd8, 32'h8888);
         else        chk8("restarve", c, 1'b0, 1'b0, 1'b1, 5'd2, 32'h2222);
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
